// File: rtl/rsa_operand_seq.sv
// Operand loader and result drainer around a modular exponentiator.
// Words stream in LSW-first per operand; one run is kicked per start and the result streams out LSW-first.
module rsa_operand_seq #(
    parameter int WIDTH = 1024,
    parameter int WORD  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [1:0]           wr_sel,
    input  logic [WORD-1:0]      wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 err,
    output logic                 exp_rst_n,
    output logic [2*WIDTH-1:0]   exp_base,
    output logic [2*WIDTH-1:0]   exp_modulo,
    output logic [2*WIDTH-1:0]   exp_exponent,
    input  logic                 exp_finish,
    input  logic [2*WIDTH-1:0]   exp_result,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [WORD-1:0]      rd_data,
    output logic                 rd_last,
    output logic [1:0]           dbg_state
);
    localparam int OPW = 2 * WIDTH;
    localparam int NW  = OPW / WORD;
    localparam int CW  = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, KICK = 2'd1, RUN = 2'd2, DRAIN = 2'd3} state_t;

    // Handshakes: a word moves on any rising edge where valid and ready are both high;
    // the producer holds valid/data stable until that edge.
    state_t          r_state;
    logic [OPW-1:0]  r_ops [3];
    logic [CW-1:0]   r_cnt [3];
    logic [2:0]      r_loaded;
    logic [OPW-1:0]  r_res;
    logic [CW-1:0]   r_rcnt;
    logic            r_rd_valid;
    logic            r_err;
    logic            r_exp_rst_n;
    logic            w_wr_acc;
    logic            w_op_sel;
    logic [CW-1:0]   w_cnt;

    assign wr_ready     = (r_state == IDLE) && !start;
    assign w_wr_acc     = wr_valid && wr_ready;
    assign w_op_sel     = (wr_sel != 2'd3);
    assign w_cnt        = w_op_sel ? r_cnt[wr_sel] : '0;
    assign busy         = (r_state != IDLE);
    assign err          = r_err;
    assign exp_rst_n    = r_exp_rst_n;
    assign exp_base     = r_ops[0];
    assign exp_modulo   = r_ops[1];
    assign exp_exponent = r_ops[2];
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_res[WORD-1:0];
    assign rd_last      = r_rd_valid && (r_rcnt == CW'(NW - 1));
    assign dbg_state    = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            for (int i = 0; i < 3; i++) begin
                r_ops[i] <= '0;
                r_cnt[i] <= '0;
            end
            r_loaded    <= '0;
            r_res       <= '0;
            r_rcnt      <= '0;
            r_rd_valid  <= 1'b0;
            r_err       <= 1'b0;
            r_exp_rst_n <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (&r_loaded) r_state <= KICK;
                        else           r_err   <= 1'b1;
                    end else if (w_wr_acc) begin
                        if (w_op_sel) begin
                            r_ops[wr_sel][w_cnt*WORD +: WORD] <= wr_data;
                            r_cnt[wr_sel] <= (w_cnt == CW'(NW - 1)) ? '0 : w_cnt + 1'b1;
                            // Set after clear so a single-word operand ends up loaded.
                            if (w_cnt == '0)            r_loaded[wr_sel] <= 1'b0;
                            if (w_cnt == CW'(NW - 1))   r_loaded[wr_sel] <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                KICK: r_state <= RUN;
                RUN: begin
                    // Release lags RUN entry by one cycle; finish is only trusted once released.
                    if (r_exp_rst_n && exp_finish) begin
                        r_res       <= exp_result;
                        r_rcnt      <= '0;
                        r_rd_valid  <= 1'b1;
                        r_exp_rst_n <= 1'b0;
                        r_state     <= DRAIN;
                    end else begin
                        r_exp_rst_n <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (rd_ready) begin
                        r_res <= r_res >> WORD;
                        if (r_rcnt == CW'(NW - 1)) begin
                            r_rcnt     <= '0;
                            r_rd_valid <= 1'b0;
                            r_state    <= IDLE;
                        end else begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_operand_seq.sv
// Directed bench for rsa_operand_seq at WIDTH=32, WORD=32 (two words per operand).
// The bench plays the exponentiator, returning hand-computed results on demand.
module tb_rsa_operand_seq;
    localparam int WIDTH = 32;
    localparam int WORD  = 32;
    localparam int OPW   = 2 * WIDTH;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [1:0]      wr_sel = 2'd0;
    logic [WORD-1:0] wr_data = '0;
    logic            start = 1'b0;
    logic            busy;
    logic            err;
    logic            exp_rst_n;
    logic [OPW-1:0]  exp_base;
    logic [OPW-1:0]  exp_modulo;
    logic [OPW-1:0]  exp_exponent;
    logic            exp_finish = 1'b0;
    logic [OPW-1:0]  exp_result = '0;
    logic            rd_valid;
    logic            rd_ready = 1'b0;
    logic [WORD-1:0] rd_data;
    logic            rd_last;
    logic [1:0]      dbg_state;

    int checks = 0;
    int errors = 0;

    rsa_operand_seq #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_sel(wr_sel), .wr_data(wr_data), .start(start), .busy(busy), .err(err),
        .exp_rst_n(exp_rst_n), .exp_base(exp_base), .exp_modulo(exp_modulo),
        .exp_exponent(exp_exponent), .exp_finish(exp_finish), .exp_result(exp_result),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [WORD-1:0] data);
        wr_valid = 1'b1;
        wr_sel   = sel;
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
    endtask

    // One complete run: kick, release timing, optional ignored start, stalled drain.
    task automatic do_run(input logic [OPW-1:0] res, input logic [WORD-1:0] w0,
                          input logic [WORD-1:0] w1, input bit poke_start);
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_valid = 1'b0;
        chk("kick_busy", busy, 1);
        chk("kick_exp_rst_n", exp_rst_n, 0);
        tick();
        chk("run1_exp_rst_n", exp_rst_n, 0);
        tick();
        chk("run_release", exp_rst_n, 1);
        chk("run_wr_ready", wr_ready, 0);
        if (poke_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("run_start_no_err", err, 0);
            chk("run_start_state", dbg_state, 2);
        end
        exp_result = res;
        exp_finish = 1'b1;
        tick();
        exp_finish = 1'b0;
        chk("drain_exp_rst_n", exp_rst_n, 0);
        chk("drain_valid", rd_valid, 1);
        chk("drain_w0", rd_data, w0);
        chk("drain_last0", rd_last, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_w0", rd_data, w0);
            chk("stall_valid", rd_valid, 1);
            chk("stall_last", rd_last, 0);
        end
        rd_ready = 1'b1;
        tick();
        chk("drain_w1", rd_data, w1);
        chk("drain_last1", rd_last, 1);
        chk("drain_busy", busy, 1);
        tick();
        rd_ready = 1'b0;
        chk("done_valid", rd_valid, 0);
        chk("done_busy", busy, 0);
        tick();
        chk("idle_no_extra", rd_valid, 0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_exp_rst_n", exp_rst_n, 0);
        chk("rst_base", exp_base, 0);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_wr_ready", wr_ready, 1);

        // Load base=4, modulo=497, exponent=13; 4^13 mod 497 = 445
        wr(2'd0, 32'd4);   wr(2'd0, 32'd0);
        wr(2'd1, 32'd497); wr(2'd1, 32'd0);
        wr(2'd2, 32'd13);  wr(2'd2, 32'd0);
        chk("load_base", exp_base, 64'd4);
        chk("load_mod", exp_modulo, 64'd497);
        chk("load_exp", exp_exponent, 64'd13);
        start = 1'b1;
        #1;
        chk("start_blocks_wr", wr_ready, 0);
        do_run(64'd445, 32'd445, 32'd0, 1'b1);
        chk("run_keeps_base", exp_base, 64'd4);
        chk("run_keeps_exp", exp_exponent, 64'd13);

        // Exponent rewritten to 0; base and modulo reused
        wr(2'd2, 32'd0); wr(2'd2, 32'd0);
        chk("rewrite_exp", exp_exponent, 64'd0);
        do_run(64'd1, 32'd1, 32'd0, 1'b0);

        // start and write in the same IDLE cycle: write dropped
        wr_valid = 1'b1;
        wr_sel   = 2'd2;
        wr_data  = 32'd99;
        start    = 1'b1;
        #1;
        chk("same_cycle_wr_ready", wr_ready, 0);
        do_run(64'd1, 32'd1, 32'd0, 1'b0);
        chk("same_cycle_exp_kept", exp_exponent, 64'd0);
        chk("same_cycle_base_kept", exp_base, 64'd4);

        // Reset mid-RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("midrun_release", exp_rst_n, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_exp_rst_n", exp_rst_n, 0);
        chk("midrun_rst_base", exp_base, 0);
        tick();
        chk("midrun_no_rd_valid", rd_valid, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("flags_clear_err", err, 1);
        chk("flags_clear_busy", busy, 0);
        tick();
        chk("err_one_cycle", err, 0);

        // Base and exponent only: start rejected
        wr(2'd0, 32'd4);  wr(2'd0, 32'd0);
        wr(2'd2, 32'd13); wr(2'd2, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("nomod_err", err, 1);
        chk("nomod_busy", busy, 0);
        chk("nomod_exp_rst_n", exp_rst_n, 0);
        tick();
        chk("nomod_err_pulse", err, 0);
        chk("nomod_busy_stays", busy, 0);

        // Reserved select: discarded, err pulse
        wr(2'd3, 32'd5);
        chk("sel3_err", err, 1);
        chk("sel3_base_kept", exp_base, 64'd4);
        tick();
        chk("sel3_err_pulse", err, 0);

        // Counter wrapped: next base word lands at word 0 and clears base flag
        wr(2'd1, 32'd497); wr(2'd1, 32'd0);
        wr(2'd0, 32'd7);
        chk("wrap_base", exp_base, 64'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("partial_base_err", err, 1);
        chk("partial_base_busy", busy, 0);
        wr(2'd0, 32'd1);
        chk("base_hi_word", exp_base, 64'h0000_0001_0000_0007);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("full_load_err", err, 0);
        chk("full_load_busy", busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
